// File: rtl/sev_seg_pkg.sv
// Shared constants and types for the seven-segment history pager.
// The table is indexed by nibble value; segments are {g,f,e,d,c,b,a}, active-low.
package sev_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef logic [1:0] digit_idx_t;
    typedef logic [1:0] page_idx_t;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    function automatic logic [3:0] anode_for(input digit_idx_t d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
    import sev_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/sev_seg_pager.sv
// Pages through the four 16-bit words of the history register and scans the
// selected word onto a 4-digit common-anode display; dp marks the page index.
module sev_seg_pager
    import sev_seg_pkg::*;
#(
    parameter int REFRESH_CYCLES = 100000,
    parameter int SCROLL_CYCLES  = 100000000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [63:0] q,
    input  logic        next_pg,
    input  logic        auto,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [1:0]  page
);

    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int SCR_W = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [SCR_W-1:0] SCR_LAST = SCR_W'(SCROLL_CYCLES - 1);

    logic [REF_W-1:0] ref_cnt;
    logic [SCR_W-1:0] scr_cnt;
    digit_idx_t       digit;
    page_idx_t        page_sel;
    logic             next_prev;

    logic             ref_tc;
    logic             scr_tc;
    logic             pg_edge;
    logic [3:0]       nibble;
    logic [6:0]       seg_next;

    assign ref_tc  = (ref_cnt == REF_LAST);
    assign scr_tc  = auto && (scr_cnt == SCR_LAST);
    assign pg_edge = next_pg && !next_prev;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ref_cnt <= '0;
            digit   <= '0;
        end else if (ref_tc) begin
            ref_cnt <= '0;
            digit   <= digit + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // A button edge and a scroll terminal count in the same cycle still
    // advance the page only once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            page_sel  <= '0;
            scr_cnt   <= '0;
            next_prev <= 1'b0;
        end else begin
            next_prev <= next_pg;
            if (pg_edge || scr_tc) begin
                page_sel <= page_sel + 2'd1;
                scr_cnt  <= '0;
            end else if (auto) begin
                scr_cnt  <= scr_cnt + 1'b1;
            end else begin
                scr_cnt  <= '0;
            end
        end
    end

    // q is deliberately not latched so upstream writes show up immediately.
    assign nibble = q[{page_sel, digit, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (seg_next)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= anode_for(digit);
            seg <= seg_next;
            dp  <= (digit != page_sel);
        end
    end

    assign page = page_sel;

endmodule

// File: tb/tb_sev_seg_pager.sv
// Self-checking bench for sev_seg_pager: directed scenarios plus random
// stimulus, all checked against a cycle-count based reference model.
module tb_sev_seg_pager;

    localparam int R = 4;
    localparam int S = 16;
    localparam logic [63:0] Q_INIT = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        clr;
    logic [63:0] q;
    logic        next_pg;
    logic        auto;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  page;

    always #5 clk = ~clk;

    sev_seg_pager #(
        .REFRESH_CYCLES (R),
        .SCROLL_CYCLES  (S)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .q       (q),
        .next_pg (next_pg),
        .auto    (auto),
        .seg     (seg),
        .dp      (dp),
        .an      (an),
        .page    (page)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] hex_ref [16];

    // reference model: edges since reset, displayed page, auto cycles since last page change
    int   m_edges;
    int   m_page;
    int   m_elapsed;
    logic m_prev;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_edges   = 0;
        m_page    = 0;
        m_elapsed = 0;
        m_prev    = 1'b0;
    endtask

    // Advance one clock; check outputs produced by the pre-edge state and inputs.
    task automatic step();
        int         d;
        logic [3:0] nib;
        logic [3:0] exp_an;
        logic       btn_edge;
        @(posedge clk);
        #1;
        d      = (m_edges / R) % 4;
        nib    = 4'((q >> (16 * m_page + 4 * d)) & 64'hF);
        exp_an = 4'b1111;
        exp_an[d] = 1'b0;
        chk("an", 64'(an), 64'(exp_an));
        chk("seg", 64'(seg), 64'(hex_ref[nib]));
        chk("dp", 64'(dp), (d == m_page) ? 64'd0 : 64'd1);

        btn_edge = next_pg && !m_prev;
        if (auto) m_elapsed++;
        else      m_elapsed = 0;
        if (btn_edge || m_elapsed == S) begin
            m_page    = (m_page + 1) % 4;
            m_elapsed = 0;
        end
        m_prev = next_pg;
        m_edges++;
        chk("page", 64'(page), 64'(m_page));
    endtask

    // Entered shortly after a rising edge; reset is asserted and released off-edge.
    task automatic do_reset();
        #2 clr = 1'b1;
        #1;
        chk("rst_an", 64'(an), 64'hF);
        chk("rst_seg", 64'(seg), 64'h7F);
        chk("rst_dp", 64'(dp), 64'd1);
        chk("rst_page", 64'(page), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_an", 64'(an), 64'hF);
        #2 clr = 1'b0;
        model_reset();
    endtask

    initial begin
        int p;
        int found;

        hex_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        clr     = 1'b0;
        next_pg = 1'b0;
        auto    = 1'b0;
        q       = Q_INIT;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // run into the middle of a scan, then reset asynchronously
        repeat (6) step();
        do_reset();
        step();
        chk("first_an", 64'(an), 64'b1110);
        chk("first_seg", 64'(seg), 64'b0001110);
        chk("first_dp", 64'(dp), 64'd0);

        // full scan with wrap
        repeat (20) step();

        // manual paging with long button holds
        for (int k = 0; k < 4; k++) begin
            next_pg = 1'b1;
            repeat (10) step();
            chk("manual_page", 64'(page), 64'((k + 1) % 4));
            next_pg = 1'b0;
            repeat (6) step();
        end

        // auto-scroll, then pause and resume
        auto = 1'b1;
        repeat (70) step();
        auto = 1'b0;
        repeat (7) step();
        auto = 1'b1;
        p = int'(page);
        repeat (15) begin
            step();
            chk("auto_hold", 64'(page), 64'(p));
        end
        step();
        chk("auto_resume", 64'(page), 64'((p + 1) % 4));

        // button edge on the same cycle as the scroll terminal count
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (m_page == 2 && m_elapsed == S - 1) found = 1;
            else step();
        end
        chk("collision_reach", 64'(found), 64'd1);
        next_pg = 1'b1;
        step();
        chk("collision_page", 64'(page), 64'd3);
        next_pg = 1'b0;
        repeat (15) begin
            step();
            chk("collision_hold", 64'(page), 64'd3);
        end
        step();
        chk("collision_next", 64'(page), 64'd0);

        // live data on page 0, digit 0
        auto = 1'b0;
        do_reset();
        q = Q_INIT;
        step();
        q[3:0] = 4'h8;
        step();
        chk("live_seg", 64'(seg), 64'b0000000);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) q = {$urandom, $urandom};
            if ($urandom_range(5) == 0) next_pg = ~next_pg;
            if ($urandom_range(19) == 0) auto = ~auto;
            if ($urandom_range(149) == 0) do_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
